// File: rtl/alu_pkg.sv
`default_nettype none
//============================================================================
// Module      : alu_pkg
// Description : Shared definitions for the two-stage add/subtract pipeline:
//               operation encoding, flag bit positions and small decode
//               helpers used by both pipeline stages.
// Revision    : 1.0  initial release
//============================================================================
package alu_pkg;

  // Operation encoding as presented on the mode port.
  typedef enum logic [1:0] {
    ADD    = 2'b00,
    SUB    = 2'b01,
    PASS_B = 2'b10,
    NOT_B  = 2'b11
  } mode_e;

  // Bit positions inside the 4-bit flags word {N,Z,C,V}.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // ADD/SUB produce meaningful carry and overflow; the B-only modes do not.
  function automatic logic mode_is_arith(input mode_e m);
    return (m == ADD) || (m == SUB);
  endfunction

  // SUB adds ~b (+1), NOT_B passes ~b through a zero A operand.
  function automatic logic mode_inverts_b(input mode_e m);
    return (m == SUB) || (m == NOT_B);
  endfunction

  // The +1 of two's-complement subtraction enters as the low carry-in.
  function automatic logic mode_carry_in(input mode_e m);
    return (m == SUB);
  endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/addsub_slice.sv
`default_nettype none
//============================================================================
// Module      : addsub_slice
// Description : One slice of the add/subtract datapath. Optionally inverts
//               the B operand, then adds A, conditioned B and a carry-in.
// Ports       : a, b       - W-bit operands
//               invert     - 1: use ~b instead of b
//               carry_in   - carry into bit 0 of the slice
//               sum        - W-bit sum
//               carry_out  - carry out of bit W-1
// Revision    : 1.0  initial release
//============================================================================
module addsub_slice #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         invert,
  input  logic         carry_in,
  output logic [W-1:0] sum,
  output logic         carry_out
);

  logic [W-1:0] w_b_cond;
  logic [W:0]   w_total;

  assign w_b_cond = b ^ {W{invert}};

  // One extra bit on every term so the carry out of bit W-1 lands in w_total[W].
  assign w_total = {1'b0, a} + {1'b0, w_b_cond} + {{W{1'b0}}, carry_in};

  assign sum       = w_total[W-1:0];
  assign carry_out = w_total[W];

endmodule : addsub_slice
`default_nettype wire

// File: rtl/addsub_pipe.sv
`default_nettype none
//============================================================================
// Module      : addsub_pipe
// Description : Two-stage pipelined adder/subtractor with NZCV flags and a
//               valid/ready handshake on both sides.
//               Stage 1 adds the low LO_W bits and registers the low sum,
//               its carry, the conditioned upper operands and the mode.
//               Stage 2 adds the upper slice and forms result and flags.
// Ports       : clk        - clock, rising edge
//               reset_n    - asynchronous active-low reset
//               in_valid   - operation presented
//               in_ready   - operation accepted this cycle
//               a, b       - WIDTH-bit operands
//               mode       - 00 ADD, 01 SUB, 10 PASS_B, 11 NOT_B
//               out_valid  - result/flags valid
//               out_ready  - consumer takes the result
//               result     - WIDTH-bit result
//               flags      - {N,Z,C,V}
// Revision    : 1.0  initial release
//============================================================================
module addsub_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int LO_W  = WIDTH / 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  localparam int HI_W = WIDTH - LO_W;

  //--------------------------------------------------------------------------
  // Handshake control
  //--------------------------------------------------------------------------
  logic r_s1_valid;
  logic r_out_valid;
  logic w_s2_adv;
  logic w_s1_adv;
  logic w_s1_load;
  logic w_s2_load;

  // Output stage moves when empty or being drained; stage 1 moves when empty
  // or when stage 2 is moving. This gives full throughput and lets capture
  // and delivery share one edge without a bubble.
  assign w_s2_adv  = !r_out_valid || out_ready;
  assign w_s1_adv  = !r_s1_valid || w_s2_adv;
  assign in_ready  = w_s1_adv;

  // Datapath registers only load when a real operation moves into them.
  assign w_s1_load = in_valid && w_s1_adv;
  assign w_s2_load = r_s1_valid && w_s2_adv;

  //--------------------------------------------------------------------------
  // Stage 1: operand conditioning and low-slice addition
  //--------------------------------------------------------------------------
  mode_e            w_mode;
  logic             w_arith;
  logic             w_invert;
  logic             w_cin;
  logic [WIDTH-1:0] w_a_op;
  logic [HI_W-1:0]  w_b_hi_cond;
  logic [LO_W-1:0]  w_lo_sum;
  logic             w_lo_carry;

  assign w_mode   = mode_e'(mode);
  assign w_arith  = mode_is_arith(w_mode);
  assign w_invert = mode_inverts_b(w_mode);
  assign w_cin    = mode_carry_in(w_mode);

  // PASS_B and NOT_B reuse the adder with A forced to zero: 0 + b (or ~b)
  // with no carry-in gives the required result and a zero carry.
  assign w_a_op = w_arith ? a : '0;

  // Upper B bits are conditioned here so stage 2 only has to add.
  assign w_b_hi_cond = b[WIDTH-1:LO_W] ^ {HI_W{w_invert}};

  addsub_slice #(
    .W (LO_W)
  ) u_slice_lo (
    .a         (w_a_op[LO_W-1:0]),
    .b         (b[LO_W-1:0]),
    .invert    (w_invert),
    .carry_in  (w_cin),
    .sum       (w_lo_sum),
    .carry_out (w_lo_carry)
  );

  logic [LO_W-1:0] r_s1_sum_lo;
  logic            r_s1_carry_lo;
  logic [HI_W-1:0] r_s1_a_hi;
  logic [HI_W-1:0] r_s1_b_hi;
  mode_e           r_s1_mode;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_valid <= 1'b0;
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_sum_lo   <= '0;
      r_s1_carry_lo <= 1'b0;
      r_s1_a_hi     <= '0;
      r_s1_b_hi     <= '0;
      r_s1_mode     <= ADD;
    end else if (w_s1_load) begin
      r_s1_sum_lo   <= w_lo_sum;
      r_s1_carry_lo <= w_lo_carry;
      r_s1_a_hi     <= w_a_op[WIDTH-1:LO_W];
      r_s1_b_hi     <= w_b_hi_cond;
      r_s1_mode     <= w_mode;
    end
  end

  //--------------------------------------------------------------------------
  // Stage 2: upper-slice addition and flag generation
  //--------------------------------------------------------------------------
  logic [HI_W-1:0]  w_hi_sum;
  logic             w_hi_carry;
  logic [WIDTH-1:0] w_res;
  logic [3:0]       w_flags;
  logic             w_s2_arith;
  logic             w_a_sign;
  logic             w_b_sign;

  // B is already conditioned, so no inversion in the upper slice.
  addsub_slice #(
    .W (HI_W)
  ) u_slice_hi (
    .a         (r_s1_a_hi),
    .b         (r_s1_b_hi),
    .invert    (1'b0),
    .carry_in  (r_s1_carry_lo),
    .sum       (w_hi_sum),
    .carry_out (w_hi_carry)
  );

  assign w_res      = {w_hi_sum, r_s1_sum_lo};
  assign w_s2_arith = mode_is_arith(r_s1_mode);
  assign w_a_sign   = r_s1_a_hi[HI_W-1];
  assign w_b_sign   = r_s1_b_hi[HI_W-1];

  always_comb begin
    w_flags         = 4'b0000;
    w_flags[FLAG_N] = w_res[WIDTH-1];
    w_flags[FLAG_Z] = (w_res == '0);
    // Carry out of the top bit; for SUB a set carry means "no borrow".
    w_flags[FLAG_C] = w_s2_arith && w_hi_carry;
    // Overflow: adder inputs share a sign (after B inversion) but the sum's
    // sign differs from it.
    w_flags[FLAG_V] = w_s2_arith && (w_a_sign == w_b_sign) &&
                      (w_hi_sum[HI_W-1] != w_a_sign);
  end

  logic [WIDTH-1:0] r_result;
  logic [3:0]       r_flags;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid <= 1'b0;
    end else if (w_s2_adv) begin
      r_out_valid <= r_s1_valid;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_result <= '0;
      r_flags  <= 4'b0000;
    end else if (w_s2_load) begin
      r_result <= w_res;
      r_flags  <= w_flags;
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign flags     = r_flags;

endmodule : addsub_pipe
`default_nettype wire

// File: tb/tb_addsub_pipe.sv
`default_nettype none
//============================================================================
// Module      : tb_addsub_pipe
// Description : Scoreboard bench for addsub_pipe (WIDTH=64, LO_W=32).
//               The driver pushes expected results when an operation is
//               accepted; a monitor pops and compares on each delivery and
//               also checks that a stalled output stays stable.
// Revision    : 1.0  initial release
//============================================================================
module tb_addsub_pipe;

  localparam int WIDTH = 64;

  logic             clk;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [3:0]       flags;

  addsub_pipe #(
    .WIDTH (64),
    .LO_W  (32)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int acc_count = 0;
  int bp_mode = 0;  // 0: always ready, 1: random ready, 2: never ready

  logic [WIDTH-1:0] q_res[$];
  logic [3:0]       q_fl[$];

  task automatic check(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: straight arithmetic on the operation definitions.
  function automatic void model(input logic [63:0] av, input logic [63:0] bv,
                                input logic [1:0] mv,
                                output logic [63:0] r, output logic [3:0] f);
    logic [64:0] full;
    logic c, v;
    c = 1'b0;
    v = 1'b0;
    case (mv)
      2'b00: begin
        full = {1'b0, av} + {1'b0, bv};
        r = full[63:0];
        c = full[64];
        v = (av[63] == bv[63]) && (r[63] != av[63]);
      end
      2'b01: begin
        r = av - bv;
        c = (av >= bv);
        v = (av[63] != bv[63]) && (r[63] != av[63]);
      end
      2'b10:   r = bv;
      default: r = ~bv;
    endcase
    f = {r[63], (r == 64'd0), c, v};
  endfunction

  // Output-side ready pattern, updated just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (bp_mode == 0)      out_ready = 1'b1;
    else if (bp_mode == 1) out_ready = 1'($urandom_range(0, 1));
    else                   out_ready = 1'b0;
  end

  task automatic set_bp(input int m);
    bp_mode   = m;
    out_ready = (m != 2);
  endtask

  // Monitor: compare deliveries against the scoreboard and check hold.
  logic             prev_stall = 1'b0;
  logic [WIDTH-1:0] prev_res;
  logic [3:0]       prev_fl;

  always @(negedge clk) begin
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", {63'd0, out_valid}, 64'd1);
        check("hold_result", result, prev_res);
        check("hold_flags", {60'd0, flags}, {60'd0, prev_fl});
      end
      if (out_valid && out_ready) begin
        if (q_res.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output: got %h expected none", result);
        end else begin
          check("result", result, q_res.pop_front());
          check("flags", {60'd0, flags}, {60'd0, q_fl.pop_front()});
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_res   = result;
      prev_fl    = flags;
    end
  end

  // Present one operation and hold it until accepted; returns 1ns after
  // the accepting edge with in_valid still high.
  task automatic send(input logic [63:0] av, input logic [63:0] bv,
                      input logic [1:0] mv, input logic [63:0] er,
                      input logic [3:0] ef);
    logic acc;
    logic done;
    done     = 1'b0;
    in_valid = 1'b1;
    a        = av;
    b        = bv;
    mode     = mv;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      if (acc) begin
        q_res.push_back(er);
        q_fl.push_back(ef);
        acc_count++;
        done = 1'b1;
      end
    end
    #1;
    if (!done) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got no in_ready expected acceptance");
    end
  endtask

  task automatic send_rand(input logic [63:0] av, input logic [63:0] bv,
                           input logic [1:0] mv);
    logic [63:0] er;
    logic [3:0]  ef;
    model(av, bv, mv, er, ef);
    send(av, bv, mv, er, ef);
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0;
    a        = {$urandom, $urandom};
    b        = {$urandom, $urandom};
    mode     = 2'($urandom_range(0, 3));
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int i = 0; i < 200 && q_res.size() != 0; i++) @(negedge clk);
    check("drain_empty", 64'(q_res.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] pick_operand();
    case ($urandom_range(0, 6))
      0:       return 64'd0;
      1:       return 64'hFFFF_FFFF_FFFF_FFFF;
      2:       return 64'h7FFF_FFFF_FFFF_FFFF;
      3:       return 64'h8000_0000_0000_0000;
      4:       return 64'h0000_0000_FFFF_FFFF;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    mode      = 2'b00;
    out_ready = 1'b1;

    #12;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_flags", {60'd0, flags}, 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;

    // Two-cycle latency on a simple ADD.
    set_bp(0);
    send(64'd1, 64'd2, 2'b00, 64'd3, 4'b0000);
    in_valid = 1'b0;
    @(negedge clk);
    check("latency_cycle1", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    check("latency_cycle2", {63'd0, out_valid}, 64'd1);
    drain();

    // Directed boundary cases with fixed expected values.
    send(64'd5, 64'd5, 2'b01, 64'd0, 4'b0110);
    send(64'd0, 64'd1, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000);
    send(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 2'b00, 64'h8000_0000_0000_0000, 4'b1001);
    send(64'h0000_0000_FFFF_FFFF, 64'd1, 2'b00, 64'h0000_0001_0000_0000, 4'b0000);
    send(64'h1234, 64'd0, 2'b10, 64'd0, 4'b0100);
    send(64'h1234, 64'd0, 2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000);
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 2'b00, 64'd0, 4'b0110);
    drain();

    // Back-pressure: four ops with the consumer stalled.
    set_bp(2);
    acc_count = 0;
    fork
      begin
        send(64'd10, 64'd1, 2'b00, 64'd11, 4'b0000);
        send(64'd20, 64'd2, 2'b00, 64'd22, 4'b0000);
        send(64'd30, 64'd3, 2'b00, 64'd33, 4'b0000);
        send(64'd40, 64'd4, 2'b00, 64'd44, 4'b0000);
      end
      begin
        repeat (6) @(negedge clk);
        check("bp_accepted", 64'(acc_count), 64'd2);
        check("bp_in_ready", {63'd0, in_ready}, 64'd0);
        check("bp_out_valid", {63'd0, out_valid}, 64'd1);
        check("bp_first_result", result, 64'd11);
        @(posedge clk);
        #1;
        set_bp(0);
      end
    join
    drain();

    // Reset with two operations in flight.
    set_bp(2);
    send(64'd100, 64'd1, 2'b00, 64'd101, 4'b0000);
    send(64'd200, 64'd2, 2'b00, 64'd202, 4'b0000);
    in_valid = 1'b0;
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_result", result, 64'd0);
    check("midrst_flags", {60'd0, flags}, 64'd0);
    q_res.delete();
    q_fl.delete();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    set_bp(0);
    @(negedge clk);
    check("postrst_in_ready", {63'd0, in_ready}, 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("postrst_no_output", {63'd0, out_valid}, 64'd0);
    end
    @(posedge clk);
    #1;

    // Randomized traffic with random gaps and random consumer stalls.
    set_bp(1);
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) idle_cycle();
      else send_rand(pick_operand(), pick_operand(), 2'($urandom_range(0, 3)));
    end
    in_valid = 1'b0;
    set_bp(0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_addsub_pipe
`default_nettype wire
